sim_data_mem: RTL
=================

# sim_data_mem

Parametrised behavioural data-memory model for the 16-bit CPU's MEM stage, standing in for the board SRAM during bring-up and simulation. It adds configurable width, depth, address scaling and wait states. Requests are captured once and use a busy/done handshake, so the pipeline's stall logic can be exercised. Out-of-range accesses are flagged, and every access reports which physical RAM it maps to.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, byte-address width
- DEPTH, 32, number of words; power of two, ≥2
- ADDR_SHIFT, 2, right-shift from address to word index
- WAIT_CYCLES, 1, extra wait states per access (0..15)
- RAM2_BASE, 16'h0000, addresses ≥ this map to Ram2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- mem_read  in  1  read request
- mem_write  in  1  write request
- rdata  out  DATA_W  read data, valid while done=1
- busy  out  1  request accepted, not yet completed
- done  out  1  one-cycle completion pulse
- fault  out  1  with done: index ≥ DEPTH, access suppressed
- addr_src  out  1  0 = Ram1, 1 = Ram2; for the accepted request

## Operation
- States: IDLE, WAIT, ACCESS.
- IDLE with mem_read|mem_write: latch addr, wdata, op (read wins if both), addr_src = (addr ≥ RAM2_BASE).
  - Go to WAIT with cnt=WAIT_CYCLES-1, or to ACCESS if WAIT_CYCLES=0.
- WAIT: inputs ignored. Decrement cnt; at cnt=0 go to ACCESS.
- ACCESS: idx = latched addr >> ADDR_SHIFT, compared at full ADDR_W width before truncation.
  - idx ≥ DEPTH: fault=1, memory and rdata unchanged.
  - Read: rdata ← mem[idx].
  - Write: mem[idx] ← wdata; rdata holds its previous value.
  - In all cases: done=1, then go to IDLE.
- busy=1 in WAIT and ACCESS, and in the cycle after acceptance.
- Master holds its request until it sees done. A request still asserted in the done cycle is sampled as a new request.
- Reset contents: mem[i] = all-ones << i for i < DATA_W; mem[i] = 0 for i ≥ DATA_W.

## Timing
- Request sampled at edge k (state IDLE) → done high in the cycle after edge k+WAIT_CYCLES+1.
- Latency: WAIT_CYCLES+2 cycles from request to done; done lasts exactly 1 cycle.
- done, fault, rdata and addr_src are registered; no combinational path from inputs to outputs.
- Back-to-back: a new request is sampled at edge k+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+2 cycles.
- Reset values: rdata=0, busy=0, done=0, fault=0, addr_src=0, state=IDLE, cnt=0.
- Reset asserted mid-access: the access is aborted immediately; a pending write never lands; memory reloads the init pattern.

## Structure
- Package sim_mem_pkg holds:
  - state enum {IDLE, WAIT, ACCESS};
  - init-pattern function init_word(i, DATA_W);
  - clog2 helper for the index and cnt widths.
- One sub-module, sim_mem_array: a DEPTH×DATA_W register array with asynchronous reset init, one write port and one registered read port, driven by the FSM.
- FSM, wait counter, address decode and range check stay in the top level.

## Test plan
- After reset, read addr 0x000C with defaults: done after 3 cycles, rdata=16'hFFF8, fault=0, addr_src=1.
- Write 16'hA5A5 to 0x0014, then read 0x0014: first done has rdata unchanged; second done has rdata=16'hA5A5.
- Read 0x0080 (idx 32, DEPTH=32): fault=1 with done, rdata unchanged, no array entry modified.
- mem_read=mem_write=1 at 0x0000 with wdata=0: read performed, rdata=16'hFFFF, mem[0] still 16'hFFFF.
- WAIT_CYCLES=0 and 3, RAM2_BASE=16'h8000: done latency 2 and 5 cycles; addr 0x7FFC gives addr_src=0, addr 0x8000 gives addr_src=1 (fault=1, idx ≥ DEPTH).
- Assert rst during WAIT of a write to 0x0004: all outputs return to 0 at once; a later read of 0x0004 returns 16'hFFFE.

Source files
------------

// File: rtl/sim_mem_pkg.sv
// Shared types and helpers for the behavioural data-memory model.
// Holds the FSM state enum, the reset-content pattern and a width helper.
package sim_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  localparam int unsigned MaxDataW = 64;

  // Minimum bit width able to index `value` entries; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

  // Word i holds all-ones shifted left by i, so each low word is distinguishable.
  function automatic logic [MaxDataW-1:0] init_word(input int unsigned i,
                                                    input int unsigned data_w);
    if (i < data_w) return {MaxDataW{1'b1}} << i;
    return '0;
  endfunction

endpackage

// File: rtl/sim_mem_array.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
// Asynchronous reset reloads the init pattern and clears the read register.
module sim_mem_array
  import sim_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= DATA_W'(init_word(i, DATA_W));
      end
      rdata <= '0;
    end else begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/sim_data_mem.sv
// Behavioural data memory for the MEM stage: captured request, wait states,
// busy/done handshake, out-of-range flagging and Ram1/Ram2 source reporting.
module sim_data_mem
  import sim_mem_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DEPTH       = 32,
  parameter int unsigned       ADDR_SHIFT  = 2,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RAM2_BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              addr_src
);

  localparam int unsigned IDX_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(WAIT_CYCLES + 1);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(DEPTH);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_write;

  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic              oob;
  logic              arr_we;
  logic              arr_re;

  always_comb begin
    idx_full = addr_q >> ADDR_SHIFT;
    oob      = ({1'b0, idx_full} >= DepthLimit);
    idx      = idx_full[IDX_W-1:0];
    arr_we   = (state == ACCESS) && op_write && !oob;
    arr_re   = (state == ACCESS) && !op_write && !oob;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      addr_src <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= mem_write && !mem_read;
            addr_src <= (addr >= RAM2_BASE);
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= ACCESS;
          else           cnt   <= cnt - 1'b1;
        end
        ACCESS: begin
          done  <= 1'b1;
          fault <= oob;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sim_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule
